// File: rtl/conv2d_stream_if.sv
// Result stream of the convolution engine: one pixel plus its raster position per valid/ready beat.
interface conv2d_stream_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROW_W  = 2,
  parameter int unsigned COL_W  = 2
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              last;

  modport master (output valid, data, row, col, last, input ready);
  modport slave  (input valid, data, row, col, last, output ready);
endinterface

// File: rtl/conv2d_stream_engine.sv
// Single-channel fixed-point 2-D convolution: captures map, kernel and bias on start, then
// streams one rounded, saturated (optionally ReLU'd) pixel per window in row-major order.
module conv2d_stream_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned IN_H   = 4,
  parameter int unsigned IN_W   = 4,
  parameter int unsigned KERNEL = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_start,
  input  logic                                      i_relu_en,
  input  logic [IN_H-1:0][IN_W-1:0][DATA_W-1:0]     i_input_feature,
  input  logic [KERNEL-1:0][KERNEL-1:0][DATA_W-1:0] i_kernel_weights,
  input  logic [DATA_W-1:0]                         i_bias,
  output logic                                      o_busy,
  output logic                                      o_done,
  conv2d_stream_if.master                           out_if
);
  localparam int unsigned OUT_H = (IN_H - KERNEL) / STRIDE + 1;
  localparam int unsigned OUT_W = (IN_W - KERNEL) / STRIDE + 1;
  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(KERNEL * KERNEL) + 1;
  localparam int unsigned ROW_W = $clog2(OUT_H) + 1;
  localparam int unsigned COL_W = $clog2(OUT_W) + 1;
  localparam int unsigned RI_W  = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int unsigned CI_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned KI_W  = (KERNEL > 1) ? $clog2(KERNEL) : 1;

  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(64'd1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StEmit, StDone} state_e;

  state_e r_state, w_state_next;

  logic [IN_H-1:0][IN_W-1:0][DATA_W-1:0]     r_feat;
  logic [KERNEL-1:0][KERNEL-1:0][DATA_W-1:0] r_wgt;
  logic [DATA_W-1:0]                         r_bias;
  logic                                      r_relu;
  logic [ROW_W-1:0]                          r_row, r_out_row;
  logic [COL_W-1:0]                          r_col, r_out_col;
  logic [DATA_W-1:0]                         r_data;
  logic                                      r_last;

  logic                       w_last_pos;
  logic [RI_W-1:0]            w_ri;
  logic [CI_W-1:0]            w_ci;
  logic [KI_W-1:0]            w_ki, w_kj;
  logic [DATA_W-1:0]          w_fx, w_wx;
  logic signed [2*DATA_W-1:0] w_fx_ext, w_wx_ext, w_prod;
  logic signed [ACC_W-1:0]    w_acc, w_bias_ext, w_sum, w_shr;
  logic [DATA_W-1:0]          w_sat, w_result;

  assign w_last_pos = (r_row == ROW_W'(OUT_H - 1)) && (r_col == COL_W'(OUT_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = StMac;
      StMac:   w_state_next = StEmit;
      StEmit:  if (out_if.ready) w_state_next = r_last ? StDone : StMac;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Window sum at full precision; products are sign-extended before multiplying.
  always_comb begin
    w_acc    = '0;
    w_ri     = '0;
    w_ci     = '0;
    w_ki     = '0;
    w_kj     = '0;
    w_fx     = '0;
    w_wx     = '0;
    w_fx_ext = '0;
    w_wx_ext = '0;
    w_prod   = '0;
    for (int i = 0; i < KERNEL; i++) begin
      for (int j = 0; j < KERNEL; j++) begin
        w_ri     = RI_W'(int'(r_row) * STRIDE + i);
        w_ci     = CI_W'(int'(r_col) * STRIDE + j);
        w_ki     = KI_W'(i);
        w_kj     = KI_W'(j);
        w_fx     = r_feat[w_ri][w_ci];
        w_wx     = r_wgt[w_ki][w_kj];
        w_fx_ext = {{DATA_W{w_fx[DATA_W-1]}}, w_fx};
        w_wx_ext = {{DATA_W{w_wx[DATA_W-1]}}, w_wx};
        w_prod   = w_fx_ext * w_wx_ext;
        w_acc    = w_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
      end
    end
  end

  always_comb begin
    w_bias_ext = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias};
    w_sum      = w_acc + (w_bias_ext <<< FRAC_W) + ROUND;
    w_shr      = w_sum >>> FRAC_W;
    if (w_shr > SAT_MAX)      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shr < SAT_MIN) w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                      w_sat = w_shr[DATA_W-1:0];
    w_result = (r_relu && w_sat[DATA_W-1]) ? '0 : w_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_feat    <= '0;
      r_wgt     <= '0;
      r_bias    <= '0;
      r_relu    <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_data    <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_feat <= i_input_feature;
            r_wgt  <= i_kernel_weights;
            r_bias <= i_bias;
            r_relu <= i_relu_en;
            r_row  <= '0;
            r_col  <= '0;
          end
        end
        StMac: begin
          r_data    <= w_result;
          r_out_row <= r_row;
          r_out_col <= r_col;
          r_last    <= w_last_pos;
        end
        StEmit: begin
          if (out_if.ready && !r_last) begin
            if (r_col == COL_W'(OUT_W - 1)) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (r_state != StIdle);
  assign o_done       = (r_state == StDone);
  assign out_if.valid = (r_state == StEmit);
  assign out_if.data  = r_data;
  assign out_if.row   = r_out_row;
  assign out_if.col   = r_out_col;
  assign out_if.last  = r_last;
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench: a 4x4/K3/S1 engine and a 5x5/K3/S2 engine, each checked by its own monitor.
module tb_conv2d_stream_engine;
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } pix_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  a_start, a_relu, a_busy, a_done;
  logic [3:0][3:0][15:0] a_feat;
  logic [2:0][2:0][15:0] a_wgt;
  logic [15:0]           a_bias;
  logic                  a_rdy_manual, a_rdy_rand;
  bit                    rnd_a = 1'b0;
  conv2d_stream_if #(.DATA_W(16), .ROW_W(2), .COL_W(2)) a_if ();
  assign a_if.ready = rnd_a ? a_rdy_rand : a_rdy_manual;

  logic                  b_start, b_busy, b_done;
  logic [4:0][4:0][15:0] b_feat;
  logic [2:0][2:0][15:0] b_wgt;
  conv2d_stream_if #(.DATA_W(16), .ROW_W(2), .COL_W(2)) b_if ();
  assign b_if.ready = 1'b1;

  conv2d_stream_engine #(
    .DATA_W(16), .FRAC_W(8), .IN_H(4), .IN_W(4), .KERNEL(3), .STRIDE(1)
  ) dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_relu_en(a_relu), .i_input_feature(a_feat),
    .i_kernel_weights(a_wgt), .i_bias(a_bias), .o_busy(a_busy), .o_done(a_done), .out_if(a_if)
  );

  conv2d_stream_engine #(
    .DATA_W(16), .FRAC_W(8), .IN_H(5), .IN_W(5), .KERNEL(3), .STRIDE(2)
  ) dut_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_relu_en(1'b0), .i_input_feature(b_feat),
    .i_kernel_weights(b_wgt), .i_bias(16'h0000), .o_busy(b_busy), .o_done(b_done), .out_if(b_if)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  pix_t q_a[$];
  pix_t q_b[$];
  pix_t e_a, e_b;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endfunction

  function automatic void fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endfunction

  always @(negedge clk) begin
    if (!rst && a_if.valid && a_if.ready) begin
      if (q_a.size() == 0) fail("a_extra_pixel");
      else begin
        e_a = q_a.pop_front();
        check("a_pixel", {a_if.data, a_if.row, a_if.col, a_if.last}, e_a);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_if.valid && b_if.ready) begin
      if (q_b.size() == 0) fail("b_extra_pixel");
      else begin
        e_b = q_b.pop_front();
        check("b_pixel", {b_if.data, b_if.row, b_if.col, b_if.last}, e_b);
      end
    end
  end

  always @(posedge clk) begin
    #3;
    a_rdy_rand = 1'($urandom_range(0, 1));
  end

  // Uniform map/kernel; every pixel of the 2x2 output has the same expected value.
  task automatic launch_a(input logic [15:0] f, input logic [15:0] w, input logic [15:0] b,
                          input logic relu, input logic [15:0] e);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) a_feat[r][c] = f;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) a_wgt[r][c] = w;
    a_bias = b;
    a_relu = relu;
    for (int k = 0; k < 4; k++)
      q_a.push_back('{data: e, row: 2'(k / 2), col: 2'(k % 2), last: (k == 3)});
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_feat  = {16{16'h5A5A}};
    a_wgt   = {9{16'hC3C3}};
    a_bias  = 16'h7777;
    a_relu  = ~relu;
  endtask

  task automatic launch_b(input logic [15:0] w, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] ev [4];
    ev = '{e0, e1, e2, e3};
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) b_feat[r][c] = 16'((r * 5 + c) << 8);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) b_wgt[r][c] = w;
    for (int k = 0; k < 4; k++)
      q_b.push_back('{data: ev[k], row: 2'(k / 2), col: 2'(k % 2), last: (k == 3)});
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_feat  = {25{16'h3C3C}};
    b_wgt   = {9{16'h1111}};
  endtask

  // n0 is the cycle index (start sampled in cycle 0) on entry; exp_cyc 0 skips the timing check.
  task automatic wait_done(input bit sel, input int n0, input int exp_cyc);
    int n = n0;
    bit seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if ((sel ? b_done : a_done) === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) fail(sel ? "b_done_timeout" : "a_done_timeout");
    else begin
      if (exp_cyc != 0) check(sel ? "b_done_cycle" : "a_done_cycle", n, exp_cyc);
      @(posedge clk); #1;
      @(negedge clk);
      check(sel ? "b_done_one_cycle" : "a_done_one_cycle",
            {(sel ? b_done : a_done), (sel ? b_busy : a_busy)}, 2'b00);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_relu = 1'b0; a_feat = '0; a_wgt = '0; a_bias = '0;
    b_start = 1'b0; b_feat = '0; b_wgt = '0;
    a_rdy_manual = 1'b1;
    @(negedge clk);
    check("a_reset_outs", {a_busy, a_done, a_if.valid, a_if.last, a_if.data, a_if.row, a_if.col},
          '0);
    check("b_reset_outs", {b_busy, b_done, b_if.valid, b_if.last, b_if.data, b_if.row, b_if.col},
          '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic pass with latency checks
    launch_a(16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0900);
    @(negedge clk);
    check("a_cycle1_busy_valid", {a_busy, a_if.valid}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check("a_cycle2_valid", a_if.valid, 1'b1);
    @(posedge clk); #1;
    wait_done(1'b0, 3, 9);

    // Saturation, ReLU and rounding
    launch_a(16'h7F00, 16'h0100, 16'h0000, 1'b0, 16'h7FFF); wait_done(1'b0, 1, 9);
    launch_a(16'h7F00, 16'hFF00, 16'h0000, 1'b0, 16'h8000); wait_done(1'b0, 1, 9);
    launch_a(16'h0100, 16'hFF00, 16'h0000, 1'b1, 16'h0000); wait_done(1'b0, 1, 9);
    launch_a(16'h0100, 16'hFF00, 16'h0000, 1'b0, 16'hF700); wait_done(1'b0, 1, 9);
    launch_a(16'h0001, 16'h0080, 16'h0000, 1'b0, 16'h0005); wait_done(1'b0, 1, 9);
    launch_a(16'h0001, 16'h0080, 16'h0100, 1'b0, 16'h0105); wait_done(1'b0, 1, 9);

    // Stride 2: sums 54,72,144,162; the last two exceed Q8.8 range at unit weight
    launch_b(16'h0100, 16'h3600, 16'h4800, 16'h7FFF, 16'h7FFF); wait_done(1'b1, 1, 9);
    launch_b(16'h0040, 16'h0D80, 16'h1200, 16'h2400, 16'h2880); wait_done(1'b1, 1, 9);

    // Backpressure on pixel 1 with a start pulse that must be ignored
    launch_a(16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0900);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_rdy_manual = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("a_hold_pixel1", {a_if.valid, a_if.data, a_if.row, a_if.col, a_if.last},
            {1'b1, 16'h0900, 2'd0, 2'd1, 1'b0});
      @(posedge clk); #1;
    end
    a_start = 1'b0;
    a_rdy_manual = 1'b1;
    wait_done(1'b0, 9, 0);

    // Random consumer readiness
    rnd_a = 1'b1;
    launch_a(16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0900);
    wait_done(1'b0, 1, 0);
    rnd_a = 1'b0;

    // Reset while pixel 2 is held
    launch_a(16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0A00);
    repeat (4) begin @(posedge clk); #1; end
    a_rdy_manual = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("a_pixel2_held", {a_if.valid, a_if.row, a_if.col}, {1'b1, 2'd1, 2'd0});
    rst = 1'b1;
    #1;
    check("a_midpass_reset", {a_busy, a_done, a_if.valid, a_if.last, a_if.data, a_if.row, a_if.col},
          '0);
    q_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a_no_done_after_reset", {a_done, a_busy, a_if.valid}, 3'b000);
      @(posedge clk); #1;
    end
    a_rdy_manual = 1'b1;
    launch_a(16'h0001, 16'h0080, 16'h0100, 1'b0, 16'h0105);
    wait_done(1'b0, 1, 9);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
